// File: rtl/la_axi_slice_if.sv
// AXI4 bus bundle (with ATOP on AW) shared by both ports of la_axi_slice.
interface LA_AXI_BUS #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1
);
    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/la_axi_slice.sv
// AXI register slice: per-channel circular FIFOs (or wires at depth 0) plus
// outstanding-burst limiters on the AR and AW issue toward the master side.
module la_axi_slice_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);
    if (DEPTH == 0) begin : g_pass
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
        assign out_data  = in_data;
        assign empty     = 1'b1;
    end else begin : g_buf
        localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam int CNT_W = $clog2(DEPTH + 1);

        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;
        logic             push;
        logic             pop;

        // ready depends only on the fill level, never on out_ready
        assign in_ready  = rst_n && (count < CNT_W'(DEPTH));
        assign out_valid = rst_n && (count != '0);
        assign out_data  = mem[rd_ptr];
        assign empty     = (count == '0);
        assign push      = in_valid && in_ready;
        assign pop       = out_valid && out_ready;

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= in_data;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end
endmodule

module la_axi_slice #(
    parameter int AXI_ADDR_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH     = 32,
    parameter int AXI_ID_WIDTH       = 4,
    parameter int AXI_USER_WIDTH     = 1,
    parameter int AW_DEPTH           = 2,
    parameter int W_DEPTH            = 2,
    parameter int B_DEPTH            = 2,
    parameter int AR_DEPTH           = 2,
    parameter int R_DEPTH            = 2,
    parameter int MAX_RD_OUTSTANDING = 4,
    parameter int MAX_WR_OUTSTANDING = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    LA_AXI_BUS.Slave                                slv,
    LA_AXI_BUS.Master                               mst,
    output logic [$clog2(MAX_RD_OUTSTANDING+1)-1:0] rd_outstanding_o,
    output logic [$clog2(MAX_WR_OUTSTANDING+1)-1:0] wr_outstanding_o,
    output logic                                    idle_o
);
    localparam int STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int AR_W     = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 29 + AXI_USER_WIDTH;
    localparam int AW_W     = AR_W + 6;
    localparam int W_W      = AXI_DATA_WIDTH + STRB_W + 1 + AXI_USER_WIDTH;
    localparam int B_W      = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH;
    localparam int R_W      = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3 + AXI_USER_WIDTH;
    localparam int RD_CNT_W = $clog2(MAX_RD_OUTSTANDING + 1);
    localparam int WR_CNT_W = $clog2(MAX_WR_OUTSTANDING + 1);

    logic [AW_W-1:0] aw_in, aw_out;
    logic [W_W-1:0]  w_in, w_out;
    logic [B_W-1:0]  b_in, b_out;
    logic [AR_W-1:0] ar_in, ar_out;
    logic [R_W-1:0]  r_in, r_out;
    logic            aw_q_valid, aw_q_ready, ar_q_valid, ar_q_ready;
    logic            aw_empty, w_empty, b_empty, ar_empty, r_empty;
    logic            rd_room, wr_room, rd_inc, rd_dec, wr_inc, wr_dec;
    logic [RD_CNT_W-1:0] rd_cnt;
    logic [WR_CNT_W-1:0] wr_cnt;

    assign aw_in = {slv.aw_id, slv.aw_addr, slv.aw_len, slv.aw_size, slv.aw_burst,
                    slv.aw_lock, slv.aw_cache, slv.aw_prot, slv.aw_qos, slv.aw_region,
                    slv.aw_atop, slv.aw_user};
    assign {mst.aw_id, mst.aw_addr, mst.aw_len, mst.aw_size, mst.aw_burst,
            mst.aw_lock, mst.aw_cache, mst.aw_prot, mst.aw_qos, mst.aw_region,
            mst.aw_atop, mst.aw_user} = aw_out;

    assign w_in = {slv.w_data, slv.w_strb, slv.w_last, slv.w_user};
    assign {mst.w_data, mst.w_strb, mst.w_last, mst.w_user} = w_out;

    assign b_in = {mst.b_id, mst.b_resp, mst.b_user};
    assign {slv.b_id, slv.b_resp, slv.b_user} = b_out;

    assign ar_in = {slv.ar_id, slv.ar_addr, slv.ar_len, slv.ar_size, slv.ar_burst,
                    slv.ar_lock, slv.ar_cache, slv.ar_prot, slv.ar_qos, slv.ar_region,
                    slv.ar_user};
    assign {mst.ar_id, mst.ar_addr, mst.ar_len, mst.ar_size, mst.ar_burst,
            mst.ar_lock, mst.ar_cache, mst.ar_prot, mst.ar_qos, mst.ar_region,
            mst.ar_user} = ar_out;

    assign r_in = {mst.r_id, mst.r_data, mst.r_resp, mst.r_last, mst.r_user};
    assign {slv.r_id, slv.r_data, slv.r_resp, slv.r_last, slv.r_user} = r_out;

    la_axi_slice_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AW_W)) u_aw (
        .clk(clk), .rst_n(rst_n),
        .in_valid(slv.aw_valid), .in_ready(slv.aw_ready), .in_data(aw_in),
        .out_valid(aw_q_valid), .out_ready(aw_q_ready), .out_data(aw_out),
        .empty(aw_empty)
    );

    la_axi_slice_fifo #(.DEPTH(W_DEPTH), .WIDTH(W_W)) u_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(slv.w_valid), .in_ready(slv.w_ready), .in_data(w_in),
        .out_valid(mst.w_valid), .out_ready(mst.w_ready), .out_data(w_out),
        .empty(w_empty)
    );

    la_axi_slice_fifo #(.DEPTH(B_DEPTH), .WIDTH(B_W)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(mst.b_valid), .in_ready(mst.b_ready), .in_data(b_in),
        .out_valid(slv.b_valid), .out_ready(slv.b_ready), .out_data(b_out),
        .empty(b_empty)
    );

    la_axi_slice_fifo #(.DEPTH(AR_DEPTH), .WIDTH(AR_W)) u_ar (
        .clk(clk), .rst_n(rst_n),
        .in_valid(slv.ar_valid), .in_ready(slv.ar_ready), .in_data(ar_in),
        .out_valid(ar_q_valid), .out_ready(ar_q_ready), .out_data(ar_out),
        .empty(ar_empty)
    );

    la_axi_slice_fifo #(.DEPTH(R_DEPTH), .WIDTH(R_W)) u_r (
        .clk(clk), .rst_n(rst_n),
        .in_valid(mst.r_valid), .in_ready(mst.r_ready), .in_data(r_in),
        .out_valid(slv.r_valid), .out_ready(slv.r_ready), .out_data(r_out),
        .empty(r_empty)
    );

    // at the limit the head request is held in its FIFO, not dropped
    assign rd_room      = (rd_cnt < RD_CNT_W'(MAX_RD_OUTSTANDING));
    assign wr_room      = (wr_cnt < WR_CNT_W'(MAX_WR_OUTSTANDING));
    assign mst.ar_valid = ar_q_valid && rd_room;
    assign ar_q_ready   = mst.ar_ready && rd_room;
    assign mst.aw_valid = aw_q_valid && wr_room;
    assign aw_q_ready   = mst.aw_ready && wr_room;

    assign rd_inc = mst.ar_valid && mst.ar_ready;
    assign rd_dec = mst.r_valid && mst.r_ready && mst.r_last;
    assign wr_inc = mst.aw_valid && mst.aw_ready;
    assign wr_dec = mst.b_valid && mst.b_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_inc && !rd_dec) begin
                rd_cnt <= rd_cnt + RD_CNT_W'(1);
            end else if (rd_dec && !rd_inc && (rd_cnt != '0)) begin
                rd_cnt <= rd_cnt - RD_CNT_W'(1);
            end
            if (wr_inc && !wr_dec) begin
                wr_cnt <= wr_cnt + WR_CNT_W'(1);
            end else if (wr_dec && !wr_inc && (wr_cnt != '0)) begin
                wr_cnt <= wr_cnt - WR_CNT_W'(1);
            end
        end
    end

    assign rd_outstanding_o = rst_n ? rd_cnt : '0;
    assign wr_outstanding_o = rst_n ? wr_cnt : '0;
    assign idle_o = !rst_n || (aw_empty && w_empty && b_empty && ar_empty && r_empty &&
                               (rd_cnt == '0) && (wr_cnt == '0));
endmodule

// File: tb/tb_la_axi_slice.sv
// Bench for la_axi_slice: directed scenarios on two configurations plus a
// randomized AR/R/W run scored against queue-based transaction expectations.
module tb_la_axi_slice;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    LA_AXI_BUS s0 ();
    LA_AXI_BUS m0 ();
    LA_AXI_BUS s1 ();
    LA_AXI_BUS m1 ();

    logic [2:0] rd_out0, wr_out0;
    logic [1:0] rd_out1, wr_out1;
    logic       idle0, idle1;

    la_axi_slice u_dut0 (
        .clk(clk), .rst_n(rst_n), .slv(s0), .mst(m0),
        .rd_outstanding_o(rd_out0), .wr_outstanding_o(wr_out0), .idle_o(idle0)
    );

    la_axi_slice #(
        .W_DEPTH(0), .MAX_RD_OUTSTANDING(2), .MAX_WR_OUTSTANDING(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .slv(s1), .mst(m1),
        .rd_outstanding_o(rd_out1), .wr_outstanding_o(wr_out1), .idle_o(idle1)
    );

    int checks = 0;
    int failures = 0;
    int model_rd, next_id, issued;
    bit gen, ar_hs, w_hs, r_hs;
    logic        rdy;
    logic [31:0] wd;
    logic [3:0]  pend_r [$];
    logic [63:0] q_ar [$];
    logic [63:0] q_r [$];
    logic [63:0] q_w [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic init_bus();
        s0.aw_valid = 0; s0.aw_id = 0; s0.aw_addr = 0; s0.aw_len = 0; s0.aw_size = 0;
        s0.aw_burst = 0; s0.aw_lock = 0; s0.aw_cache = 0; s0.aw_prot = 0; s0.aw_qos = 0;
        s0.aw_region = 0; s0.aw_atop = 0; s0.aw_user = 0;
        s0.w_valid = 0; s0.w_data = 0; s0.w_strb = 0; s0.w_last = 0; s0.w_user = 0;
        s0.b_ready = 0; s0.r_ready = 0;
        s0.ar_valid = 0; s0.ar_id = 0; s0.ar_addr = 0; s0.ar_len = 0; s0.ar_size = 0;
        s0.ar_burst = 0; s0.ar_lock = 0; s0.ar_cache = 0; s0.ar_prot = 0; s0.ar_qos = 0;
        s0.ar_region = 0; s0.ar_user = 0;
        s1.aw_valid = 0; s1.aw_id = 0; s1.aw_addr = 0; s1.aw_len = 0; s1.aw_size = 0;
        s1.aw_burst = 0; s1.aw_lock = 0; s1.aw_cache = 0; s1.aw_prot = 0; s1.aw_qos = 0;
        s1.aw_region = 0; s1.aw_atop = 0; s1.aw_user = 0;
        s1.w_valid = 0; s1.w_data = 0; s1.w_strb = 0; s1.w_last = 0; s1.w_user = 0;
        s1.b_ready = 0; s1.r_ready = 0;
        s1.ar_valid = 0; s1.ar_id = 0; s1.ar_addr = 0; s1.ar_len = 0; s1.ar_size = 0;
        s1.ar_burst = 0; s1.ar_lock = 0; s1.ar_cache = 0; s1.ar_prot = 0; s1.ar_qos = 0;
        s1.ar_region = 0; s1.ar_user = 0;
        m0.aw_ready = 0; m0.w_ready = 0; m0.ar_ready = 0;
        m0.b_valid = 0; m0.b_id = 0; m0.b_resp = 0; m0.b_user = 0;
        m0.r_valid = 0; m0.r_id = 0; m0.r_data = 0; m0.r_resp = 0; m0.r_last = 0; m0.r_user = 0;
        m1.aw_ready = 0; m1.w_ready = 0; m1.ar_ready = 0;
        m1.b_valid = 0; m1.b_id = 0; m1.b_resp = 0; m1.b_user = 0;
        m1.r_valid = 0; m1.r_id = 0; m1.r_data = 0; m1.r_resp = 0; m1.r_last = 0; m1.r_user = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        init_bus();
        rst_n = 1'b0;
        tick();
        tick();
        // during reset
        chk("rst_ar_ready", s0.ar_ready, 0);
        chk("rst_aw_ready", s0.aw_ready, 0);
        chk("rst_r_ready", m0.r_ready, 0);
        chk("rst_ar_valid", m0.ar_valid, 0);
        chk("rst_idle", idle0, 1);
        chk("rst_rd_out", rd_out0, 0);
        chk("rst_wr_out", wr_out0, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ar_ready", s0.ar_ready, 1);
        chk("post_rst_b_ready", m0.b_ready, 1);
        chk("post_rst_r_valid", s0.r_valid, 0);

        // single read round trip
        s0.ar_valid = 1; s0.ar_id = 4'd3; s0.ar_addr = 32'h1000; s0.ar_len = 0;
        m0.ar_ready = 1;
        #1;
        chk("ar_accept", s0.ar_ready, 1);
        chk("ar_no_fallthrough", m0.ar_valid, 0);
        tick();
        s0.ar_valid = 0;
        #1;
        chk("ar_out_valid", m0.ar_valid, 1);
        chk("ar_out_addr", m0.ar_addr, 32'h1000);
        chk("ar_out_id", m0.ar_id, 3);
        chk("rd_out_pre", rd_out0, 0);
        tick();
        chk("rd_out_one", rd_out0, 1);
        chk("ar_out_gone", m0.ar_valid, 0);
        m0.r_valid = 1; m0.r_last = 1; m0.r_id = 4'd3; m0.r_data = 32'hCAFE0001;
        #1;
        chk("r_accept", m0.r_ready, 1);
        tick();
        m0.r_valid = 0;
        #1;
        chk("r_out_valid", s0.r_valid, 1);
        chk("r_out_data", s0.r_data, 32'hCAFE0001);
        chk("r_out_id", s0.r_id, 3);
        chk("rd_out_zero", rd_out0, 0);
        chk("idle_busy", idle0, 0);
        s0.r_ready = 1;
        tick();
        chk("idle_drained", idle0, 1);
        chk("r_out_gone", s0.r_valid, 0);

        // AR buffer fills at two entries, then drains in order
        m0.ar_ready = 0;
        for (int i = 1; i <= 3; i++) begin
            s0.ar_valid = 1; s0.ar_id = 4'(i); s0.ar_addr = 32'h2000 + 32'(i * 16);
            #1;
            chk("ar_fill_ready", s0.ar_ready, (i < 3));
            tick();
        end
        s0.ar_valid = 0;
        #1;
        chk("ar_hold_valid", m0.ar_valid, 1);
        chk("ar_hold_id", m0.ar_id, 1);
        m0.ar_ready = 1;
        #1;
        chk("ar_rel_id1", m0.ar_id, 1);
        tick();
        chk("ar_rel_valid2", m0.ar_valid, 1);
        chk("ar_rel_id2", m0.ar_id, 2);
        chk("ar_rel_addr2", m0.ar_addr, 32'h2020);
        chk("ar_rel_ready", s0.ar_ready, 1);
        tick();
        chk("ar_rel_empty", m0.ar_valid, 0);
        chk("rd_out_two", rd_out0, 2);
        m0.ar_ready = 0;
        do_reset();
        #1;
        chk("rst_mid_rd_out", rd_out0, 0);
        chk("rst_mid_idle", idle0, 1);

        // randomized AR/R/W traffic, then a drain phase
        model_rd = 0; ar_hs = 0; w_hs = 0; r_hs = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            gen = (cyc < 500);
            if (ar_hs) s0.ar_valid = 0;
            if (w_hs) s0.w_valid = 0;
            if (r_hs) m0.r_valid = 0;
            if (!s0.ar_valid && gen && $urandom_range(0, 1) == 1) begin
                s0.ar_valid = 1; s0.ar_id = 4'($urandom);
                s0.ar_addr = $urandom; s0.ar_len = 8'($urandom);
            end
            if (!s0.w_valid && gen && $urandom_range(0, 1) == 1) begin
                s0.w_valid = 1; s0.w_data = $urandom;
                s0.w_strb = 4'($urandom); s0.w_last = 1'($urandom);
            end
            if (!m0.r_valid && pend_r.size() != 0 && $urandom_range(0, 1) == 1) begin
                m0.r_valid = 1; m0.r_id = pend_r[0]; m0.r_data = $urandom; m0.r_last = 1;
            end
            m0.ar_ready = ($urandom_range(0, 3) != 0) || !gen;
            m0.w_ready  = ($urandom_range(0, 1) == 1) || !gen;
            s0.r_ready  = ($urandom_range(0, 1) == 1) || !gen;
            #1;
            chk("rnd_rd_cnt", rd_out0, 64'(model_rd));
            if (model_rd == 4) chk("rnd_ar_gate", m0.ar_valid, 0);
            ar_hs = s0.ar_valid && s0.ar_ready;
            w_hs  = s0.w_valid && s0.w_ready;
            r_hs  = m0.r_valid && m0.r_ready;
            if (ar_hs) q_ar.push_back({20'd0, s0.ar_id, s0.ar_addr, s0.ar_len});
            if (w_hs) q_w.push_back({27'd0, s0.w_data, s0.w_strb, s0.w_last});
            if (m0.ar_valid && m0.ar_ready) begin
                chk("rnd_ar_expected", q_ar.size() != 0, 1);
                if (q_ar.size() != 0)
                    chk("rnd_ar_payload", {20'd0, m0.ar_id, m0.ar_addr, m0.ar_len}, q_ar.pop_front());
                pend_r.push_back(m0.ar_id);
                model_rd++;
            end
            if (r_hs) begin
                q_r.push_back({28'd0, m0.r_id, m0.r_data});
                void'(pend_r.pop_front());
                model_rd--;
            end
            if (s0.r_valid && s0.r_ready) begin
                chk("rnd_r_expected", q_r.size() != 0, 1);
                if (q_r.size() != 0)
                    chk("rnd_r_payload", {28'd0, s0.r_id, s0.r_data}, q_r.pop_front());
            end
            if (m0.w_valid && m0.w_ready) begin
                chk("rnd_w_expected", q_w.size() != 0, 1);
                if (q_w.size() != 0)
                    chk("rnd_w_payload", {27'd0, m0.w_data, m0.w_strb, m0.w_last}, q_w.pop_front());
            end
            tick();
        end
        s0.ar_valid = 0; s0.w_valid = 0; m0.r_valid = 0;
        #1;
        chk("rnd_idle", idle0, 1);
        chk("rnd_rd_zero", rd_out0, 0);
        chk("rnd_ar_left", q_ar.size(), 0);
        chk("rnd_r_left", q_r.size(), 0);
        chk("rnd_w_left", q_w.size(), 0);
        m0.ar_ready = 0; m0.w_ready = 0; s0.r_ready = 0;

        // read limit of 2 on the second configuration
        s1.r_ready = 1; m1.ar_ready = 1; next_id = 0; issued = 0;
        for (int c = 0; c < 12; c++) begin
            s1.ar_valid = (next_id < 4);
            s1.ar_id = 4'(next_id);
            s1.ar_addr = 32'h3000 + 32'(next_id * 16);
            #1;
            if (m1.ar_valid && m1.ar_ready) begin
                chk("lim_ar_order", m1.ar_id, 64'(issued));
                issued++;
            end
            if (s1.ar_valid && s1.ar_ready) next_id++;
            tick();
        end
        s1.ar_valid = 0;
        #1;
        chk("lim_issued", issued, 2);
        chk("lim_gated", m1.ar_valid, 0);
        chk("lim_rd_out", rd_out1, 2);
        chk("lim_full", s1.ar_ready, 0);
        m1.r_valid = 1; m1.r_last = 1; m1.r_id = 0;
        #1;
        chk("lim_r_ready", m1.r_ready, 1);
        tick();
        m1.r_id = 1;
        #1;
        chk("lim_third_valid", m1.ar_valid, 1);
        chk("lim_third_id", m1.ar_id, 2);
        chk("lim_rd_out_one", rd_out1, 1);
        tick();
        m1.r_valid = 0; m1.ar_ready = 0;
        #1;
        chk("same_cycle_cnt", rd_out1, 1);
        chk("lim_fourth_id", m1.ar_id, 3);
        do_reset();
        #1;
        chk("lim_rst_valid", m1.ar_valid, 0);
        chk("lim_rst_rd_out", rd_out1, 0);

        // zero-depth W is pure wiring
        s1.w_valid = 1;
        for (int i = 0; i < 16; i++) begin
            rdy = 1'($urandom_range(0, 1));
            wd = (i < 8) ? 32'hDEADBEEF : $urandom;
            m1.w_ready = rdy;
            s1.w_data = wd;
            #1;
            chk("w0_ready", s1.w_ready, rdy);
            chk("w0_valid", m1.w_valid, 1);
            chk("w0_data", m1.w_data, wd);
            tick();
        end
        s1.w_valid = 0; m1.w_ready = 0;

        // write limit, then reset with two AWs parked
        m1.aw_ready = 1; next_id = 0; issued = 0;
        for (int c = 0; c < 10; c++) begin
            s1.aw_valid = (next_id < 4);
            s1.aw_id = 4'(next_id);
            s1.aw_addr = 32'h4000 + 32'(next_id * 16);
            #1;
            if (m1.aw_valid && m1.aw_ready) begin
                chk("aw_addr", m1.aw_addr, 32'h4000 + 64'(issued * 16));
                issued++;
            end
            if (s1.aw_valid && s1.aw_ready) next_id++;
            tick();
        end
        s1.aw_valid = 0;
        #1;
        chk("aw_issued", issued, 2);
        chk("aw_wr_out", wr_out1, 2);
        chk("aw_full", s1.aw_ready, 0);
        chk("aw_gated", m1.aw_valid, 0);
        chk("aw_not_idle", idle1, 0);
        do_reset();
        #1;
        chk("aw_rst_wr_out", wr_out1, 0);
        chk("aw_rst_idle", idle1, 1);
        chk("aw_rst_ready", s1.aw_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("aw_rst_no_beat", m1.aw_valid, 0);
            tick();
        end

        // B passes through; decrement at zero does not wrap
        m1.b_valid = 1; m1.b_id = 4'd5; m1.b_resp = 2'd2; s1.b_ready = 0;
        #1;
        chk("b_accept", m1.b_ready, 1);
        tick();
        m1.b_valid = 0;
        #1;
        chk("b_out_valid", s1.b_valid, 1);
        chk("b_out_id", s1.b_id, 5);
        chk("b_out_resp", s1.b_resp, 2);
        chk("b_no_wrap", wr_out1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
